uart_mmio_responder: RTL and testbench

- Memory-mapped 8N1 UART that acts as the responder on the CPU data bus.
- Decodes enable, byte-write-enable, address and data from the CPU, and returns read data one cycle later.
- Contains a TX FIFO feeding a serializer and an RX deserializer feeding an RX FIFO.
- Sits behind the peripheral address decode. Raises a level interrupt to the PLIC.

---
 rtl/uart_mmio_responder_if.sv | 11 +
 rtl/uart_mmio_responder.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_responder_if.sv
// CPU data-bus port of the UART responder: access strobe, byte enables, address and data.
interface uart_mmio_responder_if;
    logic        en_i;
    logic [3:0]  we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output en_i, we_i, addr_i, data_i, input data_o);
    modport slave  (input en_i, we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART responder: TX FIFO + serializer, RX deserializer + FIFO, level IRQ.
// Optional macro UART_LOOPBACK_EN adds STATUS[5] loopback (TX line routed into RX, pin held 1).
module uart_mmio_responder #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mmio_responder_if.slave  bus_io,
    output logic                  irq_o,
    input  logic                  iack_i,
    input  logic                  uart_rx_i,
    output logic                  uart_tx_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

    // Bus decode
    logic       bus_rd;
    logic       bus_wr0;
    logic [1:0] reg_sel;

    // TX FIFO and engine
    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    tx_mem_d [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic          tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]    tx_head;
    uart_st_e      tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;

    // RX synchronizer, engine and FIFO
    logic          rx_src;
    logic          rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
    uart_st_e      rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_push_req, rx_push, rx_pop, rx_overflow;
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_d [FIFO_DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic          rx_empty, rx_full;
    logic [7:0]    rx_head;

    // Control/status registers
    logic [31:0] data_q, data_d;
    logic [1:0]  irq_en_q, irq_en_d;
    logic        overrun_q, overrun_d;
    logic        irq_q, irq_d;
    logic        lb_bit;

`ifdef UART_LOOPBACK_EN
    logic lb_q, lb_d;
    assign lb_bit    = lb_q;
    assign rx_src    = lb_q ? tx_line_q : uart_rx_i;
    assign uart_tx_o = lb_q ? 1'b1 : tx_line_q;
`else
    assign lb_bit    = 1'b0;
    assign rx_src    = uart_rx_i;
    assign uart_tx_o = tx_line_q;
`endif

    assign bus_rd  = bus_io.en_i && (bus_io.we_i == 4'b0000);
    assign bus_wr0 = bus_io.en_i && bus_io.we_i[0];
    assign reg_sel = bus_io.addr_i[3:2];

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign tx_head  = tx_mem_q[tx_rptr_q[AW-1:0]];
    assign rx_head  = rx_mem_q[rx_rptr_q[AW-1:0]];

    // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
    assign tx_push     = bus_wr0 && (reg_sel == 2'd0) && (!tx_full || tx_pop);
    assign rx_pop      = bus_rd && (reg_sel == 2'd1) && !rx_empty;
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign rx_overflow = rx_push_req && rx_full && !rx_pop;

    always_comb begin
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q[AW-1:0]] = bus_io.data_i[7:0];
            tx_wptr_d = tx_wptr_q + PW'(1);
        end
        if (tx_pop) begin
            tx_rptr_d = tx_rptr_q + PW'(1);
        end
    end

    always_comb begin
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q[AW-1:0]] = rx_shift_q;
            rx_wptr_d = rx_wptr_q + PW'(1);
        end
        if (rx_pop) begin
            rx_rptr_d = rx_rptr_q + PW'(1);
        end
    end

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        unique case (tx_st_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b0;
                    tx_st_d    = StStart;
                end
            end
            StStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d  = '0;
                    tx_bit_d  = '0;
                    tx_line_d = tx_shift_q[0];
                    tx_st_d   = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_line_d = 1'b1;
                        tx_st_d   = StStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_line_d  = 1'b0;
                        tx_st_d    = StStart;
                    end else begin
                        tx_line_d = 1'b1;
                        tx_st_d   = StIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_st_d = StIdle;
        endcase
    end

    always_comb begin
        rx_sync1_d  = rx_src;
        rx_sync2_d  = rx_sync1_q;
        rx_prev_d   = rx_sync2_q;
        rx_st_d     = rx_st_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push_req = 1'b0;
        unique case (rx_st_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_cnt_d = '0;
                    rx_st_d  = StStart;
                end
            end
            StStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_sync2_q ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            StData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            StStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d    = '0;
                    rx_push_req = rx_sync2_q;
                    rx_st_d     = StIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_st_d = StIdle;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        irq_en_d  = irq_en_q;
        overrun_d = overrun_q;
`ifdef UART_LOOPBACK_EN
        lb_d      = lb_q;
`endif
        if (bus_rd) begin
            unique case (reg_sel)
                2'd0: data_d = {tx_full, 31'b0};
                2'd1: data_d = {rx_empty, 23'b0, (rx_empty ? 8'h00 : rx_head)};
                2'd2: data_d = {26'b0, lb_bit, overrun_q, rx_full, rx_empty, tx_full, tx_empty};
                2'd3: data_d = {30'b0, irq_en_q};
            endcase
        end
        if (bus_wr0 && (reg_sel == 2'd2)) begin
            if (bus_io.data_i[4]) begin
                overrun_d = 1'b0;
            end
`ifdef UART_LOOPBACK_EN
            lb_d = bus_io.data_i[5];
`endif
        end
        if (bus_wr0 && (reg_sel == 2'd3)) begin
            irq_en_d = bus_io.data_i[1:0];
        end
        // A new overflow outranks a simultaneous clear so no drop goes unreported.
        if (rx_overflow) begin
            overrun_d = 1'b1;
        end
        irq_d = (irq_en_q[0] && !rx_empty) ||
                (irq_en_q[1] && tx_empty && (tx_st_q == StIdle));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_st_q    <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            data_q     <= '0;
            irq_en_q   <= '0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
`ifdef UART_LOOPBACK_EN
            lb_q       <= 1'b0;
`endif
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            data_q     <= data_d;
            irq_en_q   <= irq_en_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
`ifdef UART_LOOPBACK_EN
            lb_q       <= lb_d;
`endif
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

    assign bus_io.data_o = data_q;
    assign irq_o         = irq_q;

    logic unused_inputs;
    assign unused_inputs = ^{iack_i, bus_io.addr_i[1:0], bus_io.data_i[31:8]};

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Self-checking bench for uart_mmio_responder: randomized bus/serial stimulus vs. a queue model.
module tb_uart_mmio_responder;
    localparam int unsigned Cpb   = 16;
    localparam int unsigned Depth = 8;
    localparam int unsigned Frame = 10 * Cpb;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    logic iack;
    logic uart_rx;
    logic uart_tx;

    uart_mmio_responder_if bus ();

    uart_mmio_responder #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_io   (bus.slave),
        .irq_o    (irq),
        .iack_i   (iack),
        .uart_rx_i(uart_rx),
        .uart_tx_o(uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] rxq[$];
    bit         overrun_m;

    // Frames observed on the TX pin
    logic [7:0] mon_byte[$];
    int         mon_start[$];
    bit         mon_ok[$];

    initial begin
        logic [9:0] frm;
        bit         ok;
        int         st;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0) begin
                st  = cyc;
                ok  = 1'b1;
                frm = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int k = 0; k < int'(Cpb); k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (k == 0) frm[b] = uart_tx;
                        else if (uart_tx !== frm[b]) ok = 1'b0;
                    end
                end
                if (frm[0] !== 1'b0 || frm[9] !== 1'b1) ok = 1'b0;
                mon_byte.push_back(frm[8:1]);
                mon_start.push_back(st);
                mon_ok.push_back(ok);
            end
        end
    end

    function automatic logic [31:0] model_status(input bit txf, input bit txe);
        return {26'b0, 1'b0, overrun_m, (rxq.size() == Depth), (rxq.size() == 0), txf, txe};
    endfunction

    function automatic logic [31:0] model_rxdata();
        if (rxq.size() == 0) return 32'h8000_0000;
        return {24'b0, rxq.pop_front()};
    endfunction

    task automatic clear_mon();
        mon_byte.delete();
        mon_start.delete();
        mon_ok.delete();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.data_i = d;
        @(negedge clk);
        bus.en_i = 1'b0; bus.we_i = 4'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 4'b0; bus.addr_i = a;
        @(negedge clk);
        bus.en_i = 1'b0;
        d = bus.data_o;
    endtask

    // Drives one frame plus two idle bit times; the model records what a receiver must keep.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) uart_rx = f[i];
            repeat (Cpb - 1) @(negedge clk);
        end
        @(negedge clk) uart_rx = 1'b1;
        repeat (2 * Cpb - 1) @(negedge clk);
        if (stop) begin
            if (rxq.size() < Depth) rxq.push_back(b);
            else overrun_m = 1'b1;
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int left;
        left = budget;
        while (mon_byte.size() < n && left > 0) begin
            @(negedge clk);
            left--;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        reset = 1'b1; uart_rx = 1'b1; iack = 1'b0;
        bus.en_i = 1'b0; bus.we_i = 4'b0; bus.addr_i = 4'h0; bus.data_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rxq.delete(); overrun_m = 1'b0;
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++; if (bus.data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data_o); end
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL reset_status: got %h want %h", d, e); end
        bus_write(4'h8, 4'b0010, 32'h0000_0010);
        checks++; if (bus.data_o !== e) begin errors++; $display("FAIL data_hold: got %h want %h", bus.data_o, e); end
        bus_read(4'h4, d); e = model_rxdata();
        checks++; if (d !== e) begin errors++; $display("FAIL reset_rxdata: got %h want %h", d, e); end
        bus_read(4'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_txdata: got %h want 0", d); end
        bus_read(4'hC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_irqen: got %h want 0", d); end
    endtask

    task automatic test_tx_single();
        logic [31:0] d, e;
        clear_mon();
        bus_write(4'h0, 4'b0001, 32'hFFFF_FFA5);
        wait_frames(1, Frame + 100);
        checks++;
        if (mon_byte.size() != 1 || mon_byte[0] !== 8'hA5 || !mon_ok[0]) begin
            errors++;
            $display("FAIL tx_a5: frames %0d byte %h wellformed %0d want 1 a5 1", mon_byte.size(),
                     (mon_byte.size() > 0) ? mon_byte[0] : 8'h00, (mon_ok.size() > 0) ? mon_ok[0] : 0);
        end
        repeat (4) @(negedge clk);
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL tx_done_status: got %h want %h", d, e); end
    endtask

    task automatic test_irq_tx();
        logic [31:0] d;
        logic [7:0]  b;
        clear_mon();
        bus_write(4'hC, 4'b0001, 32'h0000_0002);
        repeat (2) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_idle: got %b want 1", irq); end
        bus_write(4'hC, 4'b1110, 32'h0000_0000);
        bus_read(4'hC, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL irqen_lane: got %h want 2", d); end
        b = 8'($urandom_range(0, 255));
        bus_write(4'h0, 4'b0001, {24'h0, b});
        repeat (20) @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tx_busy: got %b want 0", irq); end
        wait_frames(1, Frame + 100);
        repeat (4) @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_done: got %b want 1", irq); end
        checks++;
        if (mon_byte.size() != 1 || mon_byte[0] !== b || !mon_ok[0]) begin
            errors++;
            $display("FAIL tx_rand: frames %0d want 1 byte %h", mon_byte.size(), b);
        end
        bus_write(4'hC, 4'b0001, 32'h0);
    endtask

    task automatic test_rx_irq();
        logic [31:0] d, e;
        bus_write(4'hC, 4'b0001, 32'h0000_0001);
        send_rx(8'h3C, 1'b1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b want 1", irq); end
        bus_read(4'h4, d); e = model_rxdata();
        checks++; if (d !== e) begin errors++; $display("FAIL rx_3c: got %h want %h", d, e); end
        bus_read(4'h4, d); e = model_rxdata();
        checks++; if (d !== e) begin errors++; $display("FAIL rx_empty_read: got %h want %h", d, e); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
        bus_write(4'hC, 4'b0001, 32'h0);
    endtask

    task automatic test_overrun();
        logic [31:0] d, e;
        for (int i = 0; i < int'(Depth) + 1; i++) send_rx(8'($urandom_range(0, 255)), 1'b1);
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL overrun_status: got %h want %h", d, e); end
        bus_read(4'h4, d); e = model_rxdata();
        checks++; if (d !== e) begin errors++; $display("FAIL overrun_head: got %h want %h", d, e); end
        bus_write(4'h8, 4'b0001, 32'h0000_0010);
        overrun_m = 1'b0;
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL overrun_clear: got %h want %h", d, e); end
        for (int i = 0; i < int'(Depth); i++) begin
            bus_read(4'h4, d); e = model_rxdata();
            checks++; if (d !== e) begin errors++; $display("FAIL drain_%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_glitch_framing();
        logic [31:0] d, e;
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL glitch_status: got %h want %h", d, e); end
        send_rx(8'($urandom_range(0, 255)), 1'b0);
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL framing_status: got %h want %h", d, e); end
        send_rx(8'($urandom_range(0, 255)), 1'b1);
        bus_read(4'h4, d); e = model_rxdata();
        checks++; if (d !== e) begin errors++; $display("FAIL after_framing: got %h want %h", d, e); end
    endtask

    task automatic test_random_rx();
        logic [31:0] d, e;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk) uart_rx = 1'b0;
                @(negedge clk) uart_rx = 1'b1;
                repeat (20) @(negedge clk);
            end
            send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
        end
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL rand_status: got %h want %h", d, e); end
        for (int i = 0; i < 7; i++) begin
            bus_read(4'h4, d); e = model_rxdata();
            checks++; if (d !== e) begin errors++; $display("FAIL rand_rx_%0d: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        logic [7:0]  b [10];
        logic [7:0]  exp_q[$];
        int          occ;
        bit          busy;
        clear_mon();
        for (int i = 0; i < 10; i++) b[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.en_i = 1'b1; bus.we_i = 4'b0001; bus.addr_i = 4'h0; bus.data_i = {24'h0, b[i]};
        end
        @(negedge clk);
        bus.en_i = 1'b0; bus.we_i = 4'b0;
        bus_read(4'h8, d); e = model_status(1'b1, 1'b0);
        checks++; if (d !== e) begin errors++; $display("FAIL b2b_full: got %h want %h", d, e); end
        bus_read(4'h0, d);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL b2b_txdata: got %h want 80000000", d); end
        bus_write(4'h0, 4'b0001, {24'h0, b[9]});
        // Model: the first write goes straight to the serializer, the rest fill Depth slots.
        occ = 0; busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!busy) begin busy = 1'b1; exp_q.push_back(b[i]); end
            else if (occ < int'(Depth)) begin occ++; exp_q.push_back(b[i]); end
        end
        wait_frames(exp_q.size(), (exp_q.size() + 1) * Frame);
        repeat (2 * Frame) @(negedge clk);
        checks++;
        if (mon_byte.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count: got %0d want %0d", mon_byte.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_byte.size(); i++) begin
            checks++;
            if (mon_byte[i] !== exp_q[i] || !mon_ok[i]) begin
                errors++; $display("FAIL b2b_byte_%0d: got %h ok %0d want %h", i, mon_byte[i], mon_ok[i], exp_q[i]);
            end
            if (i > 0) begin
                checks++;
                if (mon_start[i] - mon_start[i-1] != int'(Frame)) begin
                    errors++; $display("FAIL b2b_gap_%0d: got %0d want %0d", i, mon_start[i] - mon_start[i-1], Frame);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d, e;
        bus_write(4'h0, 4'b0001, 32'h0000_0000);
        @(negedge clk) uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b want 0", uart_tx); end
        reset = 1'b1; uart_rx = 1'b1;
        @(negedge clk);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_reset_tx: got %b want 1", uart_tx); end
        reset = 1'b0;
        rxq.delete(); overrun_m = 1'b0;
        repeat (Frame) @(negedge clk);
        bus_read(4'h8, d); e = model_status(1'b0, 1'b1);
        checks++; if (d !== e) begin errors++; $display("FAIL midframe_status: got %h want %h", d, e); end
        repeat (Frame) @(negedge clk);
        clear_mon();
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_irq_tx();
        test_rx_irq();
        test_overrun();
        test_glitch_framing();
        test_random_rx();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
